// File: rtl/local_port_ni.sv
// local_port_ni: network interface joining one PE to the LOCAL port of its mesh router.
// Injection FIFO computes direction sign bits; ejection FIFO drops misdelivered packets.
`default_nettype none

module local_port_ni #(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MESH_SIDE  = 4,
  localparam int CW        = (MESH_SIDE > 1) ? $clog2(MESH_SIDE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  pe_tx_valid,
  output logic                  pe_tx_ready,
  input  logic [DATA_WIDTH-1:0] pe_tx_data,
  input  logic [CW-1:0]         pe_tx_dest_x,
  input  logic [CW-1:0]         pe_tx_dest_y,

  output logic                  noc_out_valid,
  input  logic                  noc_out_ready,
  output logic [DATA_WIDTH-1:0] noc_out_data,
  output logic [CW-1:0]         noc_out_dest_x,
  output logic [CW-1:0]         noc_out_dest_y,
  output logic                  noc_out_sdx,
  output logic                  noc_out_sdy,

  input  logic                  noc_in_valid,
  output logic                  noc_in_ready,
  input  logic [DATA_WIDTH-1:0] noc_in_data,
  input  logic [CW-1:0]         noc_in_dest_x,
  input  logic [CW-1:0]         noc_in_dest_y,

  output logic                  pe_rx_valid,
  input  logic                  pe_rx_ready,
  output logic [DATA_WIDTH-1:0] pe_rx_data,

  output logic [15:0]           tx_pkt_cnt,
  output logic [15:0]           rx_pkt_cnt,
  output logic [7:0]            misroute_cnt
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int TXW  = DATA_WIDTH + 2 * CW + 2;

  localparam logic [CW-1:0]   X_C     = CW'(X_COORD);
  localparam logic [CW-1:0]   Y_C     = CW'(Y_COORD);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Injection path: PE -> router LOCAL input
  // ---------------------------------------------------------------------------
  logic [TXW-1:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tx_wr_ptr_q;
  logic [AW-1:0]   tx_rd_ptr_q;
  logic [CNTW-1:0] tx_count_q;
  logic [CNTW-1:0] tx_count_d;
  logic            tx_full;
  logic            tx_empty;
  logic            tx_push;
  logic            tx_pop;
  logic            tx_sdx;
  logic            tx_sdy;
  logic [TXW-1:0]  tx_wdata;
  logic [TXW-1:0]  tx_head;

  assign tx_full  = (tx_count_q == DEPTH_C);
  assign tx_empty = (tx_count_q == '0);

  // Sign bits are resolved once at push time and travel with the entry.
  assign tx_sdx   = (pe_tx_dest_x < X_C);
  assign tx_sdy   = (pe_tx_dest_y < Y_C);
  assign tx_wdata = {pe_tx_data, pe_tx_dest_x, pe_tx_dest_y, tx_sdx, tx_sdy};

  assign tx_push  = pe_tx_valid && !tx_full;
  assign tx_pop   = !tx_empty && noc_out_ready;

  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
      end
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_ptr_q] <= tx_wdata;
        tx_wr_ptr_q           <= tx_wr_ptr_q + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      end
      tx_count_q <= tx_count_d;
    end
  end

  assign tx_head       = tx_mem_q[tx_rd_ptr_q];
  assign pe_tx_ready   = !tx_full;
  assign noc_out_valid = !tx_empty;
  assign {noc_out_data, noc_out_dest_x, noc_out_dest_y, noc_out_sdx, noc_out_sdy} = tx_head;

  // ---------------------------------------------------------------------------
  // Ejection path: router LOCAL output -> PE
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_ptr_q;
  logic [AW-1:0]         rx_rd_ptr_q;
  logic [CNTW-1:0]       rx_count_q;
  logic [CNTW-1:0]       rx_count_d;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_accept;
  logic                  rx_local;
  logic                  rx_push;
  logic                  rx_pop;

  assign rx_full  = (rx_count_q == DEPTH_C);
  assign rx_empty = (rx_count_q == '0);

  // Every handshake consumes the packet; only locally addressed ones are stored.
  assign rx_accept = noc_in_valid && !rx_full;
  assign rx_local  = (noc_in_dest_x == X_C) && (noc_in_dest_y == Y_C);
  assign rx_push   = rx_accept && rx_local;
  assign rx_pop    = !rx_empty && pe_rx_ready;

  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rx_mem_q[i] <= '0;
      end
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wr_ptr_q] <= noc_in_data;
        rx_wr_ptr_q           <= rx_wr_ptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      end
      rx_count_q <= rx_count_d;
    end
  end

  assign noc_in_ready = !rx_full;
  assign pe_rx_valid  = !rx_empty;
  assign pe_rx_data   = rx_mem_q[rx_rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Packet counters
  // ---------------------------------------------------------------------------
  logic [15:0] tx_pkt_cnt_q;
  logic [15:0] rx_pkt_cnt_q;
  logic [7:0]  misroute_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_pkt_cnt_q   <= '0;
      rx_pkt_cnt_q   <= '0;
      misroute_cnt_q <= '0;
    end else begin
      if (tx_pop) begin
        tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
      end
      if (rx_push) begin
        rx_pkt_cnt_q <= rx_pkt_cnt_q + 16'd1;
      end
      if (rx_accept && !rx_local && (misroute_cnt_q != 8'hFF)) begin
        misroute_cnt_q <= misroute_cnt_q + 8'd1;
      end
    end
  end

  assign tx_pkt_cnt   = tx_pkt_cnt_q;
  assign rx_pkt_cnt   = rx_pkt_cnt_q;
  assign misroute_cnt = misroute_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_local_port_ni.sv
// tb_local_port_ni: vector tables, directed corner sequences and random traffic
// checked against a queue-based model of node (1,2) in a 4x4 mesh.
`timescale 1ns/1ps
`default_nettype none

module tb_local_port_ni;

  localparam int DW = 32;
  localparam int MS = 4;
  localparam int CW = 2;
  localparam int D  = 4;
  localparam int XC = 1;
  localparam int YC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pe_tx_valid;
  logic          pe_tx_ready;
  logic [DW-1:0] pe_tx_data;
  logic [CW-1:0] pe_tx_dest_x;
  logic [CW-1:0] pe_tx_dest_y;
  logic          noc_out_valid;
  logic          noc_out_ready;
  logic [DW-1:0] noc_out_data;
  logic [CW-1:0] noc_out_dest_x;
  logic [CW-1:0] noc_out_dest_y;
  logic          noc_out_sdx;
  logic          noc_out_sdy;
  logic          noc_in_valid;
  logic          noc_in_ready;
  logic [DW-1:0] noc_in_data;
  logic [CW-1:0] noc_in_dest_x;
  logic [CW-1:0] noc_in_dest_y;
  logic          pe_rx_valid;
  logic          pe_rx_ready;
  logic [DW-1:0] pe_rx_data;
  logic [15:0]   tx_pkt_cnt;
  logic [15:0]   rx_pkt_cnt;
  logic [7:0]    misroute_cnt;

  always #5 clk = ~clk;

  local_port_ni #(
    .X_COORD(XC), .Y_COORD(YC), .FIFO_DEPTH(D), .DATA_WIDTH(DW), .MESH_SIDE(MS)
  ) dut (
    .clk(clk), .rst(rst),
    .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready), .pe_tx_data(pe_tx_data),
    .pe_tx_dest_x(pe_tx_dest_x), .pe_tx_dest_y(pe_tx_dest_y),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready), .noc_out_data(noc_out_data),
    .noc_out_dest_x(noc_out_dest_x), .noc_out_dest_y(noc_out_dest_y),
    .noc_out_sdx(noc_out_sdx), .noc_out_sdy(noc_out_sdy),
    .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready), .noc_in_data(noc_in_data),
    .noc_in_dest_x(noc_in_dest_x), .noc_in_dest_y(noc_in_dest_y),
    .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_data(pe_rx_data),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .misroute_cnt(misroute_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic          sdx;
    logic          sdy;
  } tx_pkt_t;

  typedef struct packed {
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [DW-1:0] data;
    logic          exp_sdx;
    logic          exp_sdy;
  } tx_vec_t;

  typedef struct packed {
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [DW-1:0] data;
    logic          exp_local;
  } rx_vec_t;

  tx_pkt_t       txq[$];
  logic [DW-1:0] rxq[$];
  logic [15:0]   m_tx_cnt;
  logic [15:0]   m_rx_cnt;
  int            m_mis;
  int            tests = 0;
  int            fails = 0;

  tx_vec_t tx_vecs[6];
  rx_vec_t rx_vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the handshake rules to the pre-edge state.
  task automatic model_step();
    bit      tx_acc;
    bit      tx_pop;
    bit      rx_acc;
    bit      rx_pop;
    tx_pkt_t p;
    tx_acc = pe_tx_valid && (txq.size() < D);
    tx_pop = noc_out_ready && (txq.size() > 0);
    rx_acc = noc_in_valid && (rxq.size() < D);
    rx_pop = pe_rx_ready && (rxq.size() > 0);
    if (tx_pop) begin
      void'(txq.pop_front());
      m_tx_cnt++;
    end
    if (tx_acc) begin
      p.data = pe_tx_data;
      p.dx   = pe_tx_dest_x;
      p.dy   = pe_tx_dest_y;
      p.sdx  = (int'(pe_tx_dest_x) < XC);
      p.sdy  = (int'(pe_tx_dest_y) < YC);
      txq.push_back(p);
    end
    if (rx_pop) void'(rxq.pop_front());
    if (rx_acc) begin
      if (int'(noc_in_dest_x) == XC && int'(noc_in_dest_y) == YC) begin
        rxq.push_back(noc_in_data);
        m_rx_cnt++;
      end else if (m_mis < 255) begin
        m_mis++;
      end
    end
  endtask

  task automatic check_model();
    check("pe_tx_ready", pe_tx_ready, txq.size() < D);
    check("noc_out_valid", noc_out_valid, txq.size() != 0);
    if (txq.size() != 0) begin
      check("noc_out_data", noc_out_data, txq[0].data);
      check("noc_out_dest_x", noc_out_dest_x, txq[0].dx);
      check("noc_out_dest_y", noc_out_dest_y, txq[0].dy);
      check("noc_out_sdx", noc_out_sdx, txq[0].sdx);
      check("noc_out_sdy", noc_out_sdy, txq[0].sdy);
    end
    check("noc_in_ready", noc_in_ready, rxq.size() < D);
    check("pe_rx_valid", pe_rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("pe_rx_data", pe_rx_data, rxq[0]);
    check("tx_pkt_cnt", tx_pkt_cnt, m_tx_cnt);
    check("rx_pkt_cnt", rx_pkt_cnt, m_rx_cnt);
    check("misroute_cnt", misroute_cnt, m_mis);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    pe_tx_valid   = 1'b0;
    pe_tx_data    = '0;
    pe_tx_dest_x  = '0;
    pe_tx_dest_y  = '0;
    noc_out_ready = 1'b0;
    noc_in_valid  = 1'b0;
    noc_in_data   = '0;
    noc_in_dest_x = '0;
    noc_in_dest_y = '0;
    pe_rx_ready   = 1'b0;
  endtask

  // Asserted between edges so the outputs must react without a clock.
  task automatic apply_reset();
    idle();
    rst = 1'b1;
    #1;
    txq.delete();
    rxq.delete();
    m_tx_cnt = '0;
    m_rx_cnt = '0;
    m_mis    = 0;
    check_model();
    check("rst_noc_out_data", noc_out_data, 0);
    check("rst_noc_out_dest", {noc_out_dest_x, noc_out_dest_y, noc_out_sdx, noc_out_sdy}, 0);
    check("rst_pe_rx_data", pe_rx_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask

  task automatic send_rx(input logic [CW-1:0] dx, input logic [CW-1:0] dy, input logic [DW-1:0] data);
    noc_in_valid  = 1'b1;
    noc_in_dest_x = dx;
    noc_in_dest_y = dy;
    noc_in_data   = data;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int popped;
    int pushed;
    int exp_idx;
    logic [DW-1:0] exp_rx[$];

    tx_vecs[0] = '{dx: 2'd0, dy: 2'd3, data: 32'hA5A5A5A5, exp_sdx: 1'b1, exp_sdy: 1'b0};
    tx_vecs[1] = '{dx: 2'd1, dy: 2'd2, data: 32'h0000_0001, exp_sdx: 1'b0, exp_sdy: 1'b0};
    tx_vecs[2] = '{dx: 2'd2, dy: 2'd1, data: 32'hDEAD_BEEF, exp_sdx: 1'b0, exp_sdy: 1'b1};
    tx_vecs[3] = '{dx: 2'd0, dy: 2'd0, data: 32'h1234_5678, exp_sdx: 1'b1, exp_sdy: 1'b1};
    tx_vecs[4] = '{dx: 2'd3, dy: 2'd3, data: 32'hFFFF_FFFF, exp_sdx: 1'b0, exp_sdy: 1'b0};
    tx_vecs[5] = '{dx: 2'd1, dy: 2'd1, data: 32'h8000_0000, exp_sdx: 1'b0, exp_sdy: 1'b1};

    rx_vecs[0] = '{dx: 2'd1, dy: 2'd2, data: 32'h0000_0011, exp_local: 1'b1};
    rx_vecs[1] = '{dx: 2'd2, dy: 2'd2, data: 32'h0000_0022, exp_local: 1'b0};
    rx_vecs[2] = '{dx: 2'd1, dy: 2'd2, data: 32'h0000_0033, exp_local: 1'b1};
    rx_vecs[3] = '{dx: 2'd1, dy: 2'd2, data: 32'h0000_0044, exp_local: 1'b1};

    apply_reset();

    // Single packet to (0,3) with the router ready.
    pe_tx_valid = 1'b1; pe_tx_data = 32'hA5A5A5A5; pe_tx_dest_x = 2'd0; pe_tx_dest_y = 2'd3;
    noc_out_ready = 1'b1;
    cycle();
    pe_tx_valid = 1'b0;
    check("s1_valid", noc_out_valid, 1);
    check("s1_sdx_sdy", {noc_out_sdx, noc_out_sdy}, 2'b10);
    check("s1_dest", {noc_out_dest_x, noc_out_dest_y}, 4'b0011);
    check("s1_cnt_before", tx_pkt_cnt, 0);
    cycle();
    check("s1_cnt_after", tx_pkt_cnt, 1);
    check("s1_empty", noc_out_valid, 0);

    // Sign-bit table: push one packet, inspect the head, then pop it.
    for (int i = 0; i < 6; i++) begin
      pe_tx_valid = 1'b1; pe_tx_data = tx_vecs[i].data;
      pe_tx_dest_x = tx_vecs[i].dx; pe_tx_dest_y = tx_vecs[i].dy;
      noc_out_ready = 1'b0;
      cycle();
      pe_tx_valid = 1'b0;
      check("vec_data", noc_out_data, tx_vecs[i].data);
      check("vec_sdx", noc_out_sdx, tx_vecs[i].exp_sdx);
      check("vec_sdy", noc_out_sdy, tx_vecs[i].exp_sdy);
      noc_out_ready = 1'b1;
      cycle();
    end

    // Backpressure: five pushes into a depth-4 FIFO with the router stalled.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      pe_tx_valid = 1'b1; pe_tx_data = 32'h100 + i; pe_tx_dest_x = 2'(i); pe_tx_dest_y = 2'(3 - (i % 4));
      cycle();
      if (i == 3) check("bp_ready_low", pe_tx_ready, 0);
    end
    noc_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bit acc;
      check("bp_order", noc_out_data, 32'h100 + k);
      acc = pe_tx_valid && (txq.size() < D);
      cycle();
      if (acc) pe_tx_valid = 1'b0;
    end
    check("bp_drained", noc_out_valid, 0);
    check("bp_tx_cnt", tx_pkt_cnt, 5);

    // Continuous push/pop from full; order must survive pointer wrap.
    apply_reset();
    pushed = 0;
    popped = 0;
    pe_tx_valid = 1'b1; pe_tx_data = 32'h200;
    for (int c = 0; c < 40 && popped < 10; c++) begin
      bit acc;
      bit pop;
      if (c == 4) noc_out_ready = 1'b1;
      acc = pe_tx_valid && (txq.size() < D);
      pop = noc_out_ready && (txq.size() > 0);
      if (pop) check("wrap_order", noc_out_data, 32'h200 + popped);
      cycle();
      if (pop) popped++;
      if (acc) begin
        pushed++;
        pe_tx_data = 32'h200 + pushed;
        if (pushed == 10) pe_tx_valid = 1'b0;
      end
    end
    check("wrap_done", popped, 10);

    // Ejection filtering table.
    apply_reset();
    exp_rx.delete();
    for (int i = 0; i < 4; i++) begin
      send_rx(rx_vecs[i].dx, rx_vecs[i].dy, rx_vecs[i].data);
      if (rx_vecs[i].exp_local) exp_rx.push_back(rx_vecs[i].data);
    end
    noc_in_valid = 1'b0;
    check("rx_cnt", rx_pkt_cnt, 3);
    check("rx_mis", misroute_cnt, 1);
    pe_rx_ready = 1'b1;
    exp_idx = 0;
    for (int k = 0; k < 3; k++) begin
      check("rx_valid", pe_rx_valid, 1);
      check("rx_order", pe_rx_data, exp_rx[exp_idx]);
      exp_idx++;
      cycle();
    end
    check("rx_empty", pe_rx_valid, 0);

    // Fill ejection FIFO, then saturate the misroute counter.
    apply_reset();
    for (int i = 0; i < 4; i++) send_rx(2'd1, 2'd2, 32'h300 + i);
    check("rx_full_ready", noc_in_ready, 0);
    send_rx(2'd1, 2'd2, 32'h3FF);
    check("rx_full_refused", rx_pkt_cnt, 4);
    noc_in_valid = 1'b0;
    pe_rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 300; i++) begin
      send_rx(2'd3, 2'd0, 32'(i));
      if (i == 254) check("mis_254", misroute_cnt, 255);
    end
    noc_in_valid = 1'b0;
    check("mis_sat", misroute_cnt, 255);
    check("mis_rx_cnt", rx_pkt_cnt, 4);

    // Mid-operation reset with two entries in each FIFO.
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      pe_tx_valid = 1'b1; pe_tx_data = 32'h400 + i; pe_tx_dest_x = 2'd3; pe_tx_dest_y = 2'd0;
      noc_in_valid = 1'b1; noc_in_data = 32'h500 + i; noc_in_dest_x = 2'd1; noc_in_dest_y = 2'd2;
      cycle();
    end
    check("mid_tx_valid", noc_out_valid, 1);
    check("mid_rx_valid", pe_rx_valid, 1);
    #1;
    apply_reset();
    check("mid_rst_valids", {noc_out_valid, pe_rx_valid}, 2'b00);
    check("mid_rst_readies", {pe_tx_ready, noc_in_ready}, 2'b11);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      pe_tx_valid   = ($urandom_range(0, 99) < 60);
      pe_tx_data    = $urandom;
      pe_tx_dest_x  = 2'($urandom_range(0, 3));
      pe_tx_dest_y  = 2'($urandom_range(0, 3));
      noc_out_ready = ($urandom_range(0, 99) < 50);
      noc_in_valid  = ($urandom_range(0, 99) < 60);
      noc_in_data   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        noc_in_dest_x = 2'd1;
        noc_in_dest_y = 2'd2;
      end else begin
        noc_in_dest_x = 2'($urandom_range(0, 3));
        noc_in_dest_y = 2'($urandom_range(0, 3));
      end
      pe_rx_ready   = ($urandom_range(0, 99) < 50);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
